// File: rtl/store_x_unit.sv
// STORE X executor: MAR <- X, MBR <- AC, M[MAR] <- MBR, with an optional read-back verify.
// Drives a sync-write / 1-cycle sync-read memory port under a start/done handshake.
module store_x_unit #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MEM_DEPTH = 16384,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] ac_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mar_out,
    output logic [DATA_W-1:0] mbr_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD_MBR = 3'd1;
    localparam logic [2:0] WRITE    = 3'd2;
    localparam logic [2:0] READBACK = 3'd3;
    localparam logic [2:0] CHECK    = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    // One extra bit so MEM_DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mbr_q, mbr_d;
    logic              err_q, err_d;
    logic              addr_ok;

    assign addr_ok = ({1'b0, x_addr} < DEPTH_EXT);

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mbr_d   = mbr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (addr_ok) begin
                        mar_d   = x_addr;
                        err_d   = 1'b0;
                        state_d = LOAD_MBR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            LOAD_MBR: begin
                mbr_d   = ac_in;
                state_d = WRITE;
            end
            WRITE:    state_d = VERIFY ? READBACK : DONE;
            READBACK: state_d = CHECK;
            CHECK: begin
                err_d   = (mem_rdata != mbr_q);
                state_d = DONE;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mbr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mbr_q   <= mbr_d;
            err_q   <= err_d;
        end
    end

    // Moore decodes: reset clears state_q asynchronously, so mem_we drops at once.
    assign mem_we    = (state_q == WRITE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign mar_out   = mar_q;
    assign mbr_out   = mbr_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mbr_q;

endmodule

// File: tb/tb_store_x_unit.sv
// Directed bench for store_x_unit: one verify-enabled instance and one VERIFY=0 instance,
// each backed by its own behavioural memory.
module tb_store_x_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_nv = 1'b0;
    logic [15:0] x_addr = '0;
    logic [15:0] ac_in = '0;
    logic        stuck = 1'b0;

    logic [15:0] mem_rdata, mem_addr, mem_wdata, mar_out, mbr_out;
    logic        mem_we, busy, done, err;
    logic [15:0] mem_rdata_nv, mem_addr_nv, mem_wdata_nv, mar_out_nv, mbr_out_nv;
    logic        mem_we_nv, busy_nv, done_nv, err_nv;

    logic [15:0] mem    [0:16383];
    logic [15:0] mem_nv [0:16383];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    store_x_unit #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(16384), .VERIFY(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .x_addr(x_addr), .ac_in(ac_in),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mar_out(mar_out), .mbr_out(mbr_out), .busy(busy), .done(done), .err(err)
    );

    store_x_unit #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(16384), .VERIFY(1'b0)) dut_nv (
        .clk(clk), .reset(reset), .start(start_nv), .x_addr(x_addr), .ac_in(ac_in),
        .mem_rdata(mem_rdata_nv), .mem_addr(mem_addr_nv), .mem_wdata(mem_wdata_nv),
        .mem_we(mem_we_nv), .mar_out(mar_out_nv), .mbr_out(mbr_out_nv), .busy(busy_nv),
        .done(done_nv), .err(err_nv)
    );

    // Memory model; stuck forces bit 0 low on writes to emulate a bad cell.
    always @(posedge clk) begin
        if (mem_we && mem_addr < 16'h4000)
            mem[mem_addr[13:0]] <= stuck ? (mem_wdata & 16'hFFFE) : mem_wdata;
        mem_rdata <= (mem_addr < 16'h4000) ? mem[mem_addr[13:0]] : 16'h0000;
    end

    always @(posedge clk) begin
        if (mem_we_nv && mem_addr_nv < 16'h4000) mem_nv[mem_addr_nv[13:0]] <= mem_wdata_nv;
        mem_rdata_nv <= (mem_addr_nv < 16'h4000) ? mem_nv[mem_addr_nv[13:0]] : 16'h0000;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one store on the verify instance; lat counts cycles from E0 to the done cycle.
    task automatic run_store(input logic [15:0] x, input logic [15:0] ac, output int lat,
                             output int wes, output logic err_acc);
        start  = 1'b1;
        x_addr = x;
        ac_in  = ac;
        step();
        start   = 1'b0;
        err_acc = err;
        lat     = 0;
        wes     = 0;
        while (!done && lat < 20) begin
            if (mem_we) wes++;
            step();
            lat++;
        end
    endtask

    task automatic test_basic();
        start  = 1'b1;
        x_addr = 16'h0010;
        ac_in  = 16'h1234;
        step();
        start = 1'b0;
        n_checks++;
        if ({busy, mem_we, done} !== 3'b100 || mar_out !== 16'h0010) begin
            n_fail++;
            $display("FAIL basic_e0: busy/we/done=%b mar=%h, want 100 0010",
                     {busy, mem_we, done}, mar_out);
        end
        step();
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0010 || mem_wdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL basic_write: we=%b addr=%h data=%h, want 1 0010 1234",
                     mem_we, mem_addr, mem_wdata);
        end
        step();
        n_checks++;
        if (mem_we !== 1'b0 || mem[14'h0010] !== 16'h1234) begin
            n_fail++;
            $display("FAIL basic_mem: we=%b M=%h, want 0 1234", mem_we, mem[14'h0010]);
        end
        step();
        n_checks++;
        if ({mem_we, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_e3: we/done=%b, want 00", {mem_we, done});
        end
        step();
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b err=%b, want 1 0", done, err);
        end
        step();
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_idle: done/busy=%b, want 00", {done, busy});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mar_out, mbr_out} !== 32'h0 || {err, mem_we, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle: mar=%h mbr=%h err/we/busy/done=%b, want 0 0 0000",
                     mar_out, mbr_out, {err, mem_we, busy, done});
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_boundary();
        int lat, wes;
        logic ea;
        run_store(16'h3FFF, 16'hFFFF, lat, wes, ea);
        n_checks++;
        if (lat != 4 || wes != 1 || err !== 1'b0 || mem[14'h3FFF] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL bound_last: lat=%0d we=%0d err=%b M=%h, want 4 1 0 ffff",
                     lat, wes, err, mem[14'h3FFF]);
        end
        step();
        run_store(16'h4000, 16'h5555, lat, wes, ea);
        n_checks++;
        if (lat != 0 || wes != 0 || err !== 1'b1 || ea !== 1'b1) begin
            n_fail++;
            $display("FAIL bound_oor: lat=%0d we=%0d err=%b, want 0 0 1", lat, wes, err);
        end
        n_checks++;
        if (mar_out !== 16'h3FFF) begin
            n_fail++;
            $display("FAIL bound_mar_hold: mar=%h, want 3fff", mar_out);
        end
        step();
        n_checks++;
        if ({done, busy, err} !== 3'b001) begin
            n_fail++;
            $display("FAIL bound_after: done/busy/err=%b, want 001", {done, busy, err});
        end
    endtask

    task automatic test_verify_fail();
        int lat, wes;
        logic ea;
        stuck = 1'b1;
        run_store(16'h0005, 16'h0001, lat, wes, ea);
        n_checks++;
        if (lat != 4 || done !== 1'b1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL verify_bad: lat=%0d done=%b err=%b, want 4 1 1", lat, done, err);
        end
        stuck = 1'b0;
        step();
        run_store(16'h0006, 16'h0001, lat, wes, ea);
        n_checks++;
        if (ea !== 1'b0 || err !== 1'b0 || lat != 4) begin
            n_fail++;
            $display("FAIL verify_clear: err@accept=%b err=%b lat=%0d, want 0 0 4",
                     ea, err, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [19:0] we_tr, exp_tr;
        int dn, wes;
        x_addr   = 16'h0100;
        ac_in    = 16'hA5A5;
        start_nv = 1'b1;
        dn = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            we_tr[k-1]  = mem_we_nv;
            exp_tr[k-1] = (k % 4 == 2);
            if (done_nv) dn++;
        end
        start_nv = 1'b0;
        n_checks++;
        if (we_tr !== exp_tr || dn != 5) begin
            n_fail++;
            $display("FAIL b2b_trace: we=%b dones=%0d, want %b 5", we_tr, dn, exp_tr);
        end
        n_checks++;
        if (mem_nv[14'h0100] !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL b2b_mem: M=%h, want a5a5", mem_nv[14'h0100]);
        end
        step();
        step();
        x_addr   = 16'h0200;
        ac_in    = 16'h5A5A;
        start_nv = 1'b1;
        dn  = 0;
        wes = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (mem_we_nv) wes++;
            if (done_nv) dn++;
            start_nv = (k == 1 || k == 2);
        end
        n_checks++;
        if (wes != 1 || dn != 1 || busy_nv !== 1'b0 || mem_nv[14'h0200] !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL busy_ignore: we=%0d done=%0d busy=%b M=%h, want 1 1 0 5a5a",
                     wes, dn, busy_nv, mem_nv[14'h0200]);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, wes, dn;
        logic ea;
        start  = 1'b1;
        x_addr = 16'h0020;
        ac_in  = 16'hBEEF;
        step();
        start = 1'b0;
        step();
        n_checks++;
        if (mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: we=%b, want 1", mem_we);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_we, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_async: we/busy/done=%b, want 000", {mem_we, busy, done});
        end
        step();
        reset = 1'b0;
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (done) dn++;
        end
        n_checks++;
        if (dn != 0 || mem[14'h0020] !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_nodone: dones=%0d M=%h, want 0 0000", dn, mem[14'h0020]);
        end
        run_store(16'h0020, 16'hBEEF, lat, wes, ea);
        n_checks++;
        if (lat != 4 || wes != 1 || err !== 1'b0 || mem[14'h0020] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rst_recover: lat=%0d we=%0d err=%b M=%h, want 4 1 0 beef",
                     lat, wes, err, mem[14'h0020]);
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]    = 16'h0000;
            mem_nv[i] = 16'h0000;
        end
        repeat (3) step();
        reset = 1'b0;
        step();
        test_basic();
        test_reset();
        test_boundary();
        test_verify_fail();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

endmodule
